// File: rtl/fft_out_streamer_if.sv
// Handshake bundle between the FFT output streamer and its frame producer / beat consumer.
// master = the side that produces frames and consumes beats; slave = the streamer itself.
interface fft_out_streamer_if #(
  parameter int bits = 16,
  parameter int N    = 32
);
  localparam int W     = 2 * bits;
  localparam int IDX_W = $clog2(N);

  logic               frame_valid;
  logic [N*W-1:0]     frame_in;
  logic               frame_ready;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [IDX_W-1:0]   out_index;
  logic               out_last;
  logic               busy;
  logic [7:0]         drop_cnt;

  modport master (
    output frame_valid, frame_in, out_ready,
    input  frame_ready, out_valid, out_data, out_index, out_last, busy, drop_cnt
  );

  modport slave (
    input  frame_valid, frame_in, out_ready,
    output frame_ready, out_valid, out_data, out_index, out_last, busy, drop_cnt
  );
endinterface

// File: rtl/fft_out_streamer.sv
// Captures a full N-point complex FFT frame in one cycle and streams it out one bin per beat,
// optionally in bit-reversed bank order, with a saturating count of frames that arrive while busy.
module fft_out_streamer #(
  parameter int bits    = 16,
  parameter int fix_bit = 7,
  parameter int N       = 32,
  parameter int BIT_REV = 0
) (
  input  logic              clk_100,
  input  logic              reset,
  fft_out_streamer_if.slave bus
);
  localparam int W     = 2 * bits;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // The fixed-point format only travels with the data; reject configurations that cannot describe it.
  if (N < 2 || (N & (N - 1)) != 0 || fix_bit < 0 || fix_bit >= bits) begin : g_bad_cfg
    $error("fft_out_streamer: N must be a power of two >= 2 and 0 <= fix_bit < bits");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     bank_q [N];
  logic             out_valid_q, out_last_q, busy_q;
  logic [W-1:0]     out_data_q;
  logic [7:0]       drop_cnt_q;

  logic frame_ready, accept, drop, xfer;

  function automatic logic [IDX_W-1:0] rd_addr(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] r;
    r = i;
    if (BIT_REV != 0) begin
      for (int b = 0; b < IDX_W; b++) r[b] = i[IDX_W-1-b];
    end
    return r;
  endfunction

  // A new frame may land on the same edge that retires the last beat of the current one.
  always_comb begin
    frame_ready = (state_q == IDLE) || (out_valid_q && bus.out_ready && out_last_q);
    accept      = bus.frame_valid && frame_ready;
    drop        = bus.frame_valid && !frame_ready;
    xfer        = out_valid_q && bus.out_ready;
    idx_d       = idx_q + 1'b1;
  end

  // NOTE: every register below, including the bank, is written with <= so all of them sample
  // pre-edge values; the bank is reset too so no stale bin can ever appear on out_data.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < N; i++) bank_q[i] <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N; i++) bank_q[i] <= bus.frame_in[i*W +: W];
        state_q     <= STREAM;
        idx_q       <= '0;
        out_valid_q <= 1'b1;
        busy_q      <= 1'b1;
        out_last_q  <= 1'b0;
        // Bin 0 maps to bank 0 in both orders, so it can come straight from the input.
        out_data_q  <= bus.frame_in[W-1:0];
      end else if (xfer) begin
        if (out_last_q) begin
          state_q     <= IDLE;
          idx_q       <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          out_last_q  <= 1'b0;
          out_data_q  <= '0;
        end else begin
          idx_q      <= idx_d;
          out_last_q <= (idx_d == LAST_IDX);
          out_data_q <= bank_q[rd_addr(idx_d)];
        end
      end

      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.frame_ready = frame_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_index   = idx_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_fft_out_streamer.sv
// Drives two streamers (natural and bit-reversed order) with identical stimulus and checks
// every cycle against a queue-of-expected-beats model built from the frame rules.
module tb_fft_out_streamer;
  localparam int BITS = 16;
  localparam int N    = 32;
  localparam int W    = 2 * BITS;

  typedef logic [W-1:0] word_t;

  typedef struct packed {
    logic       ov;
    logic       busy;
    logic       fr;
    logic [4:0] idx;
    word_t      data;
    logic       last;
    logic [7:0] drop;
  } view_t;

  typedef struct {
    logic [4:0] idx;
    word_t      data;
    bit         last;
  } beat_t;

  logic clk_100 = 1'b0;
  logic reset;
  always #5 clk_100 = ~clk_100;

  fft_out_streamer_if #(.bits(BITS), .N(N)) if0 ();
  fft_out_streamer_if #(.bits(BITS), .N(N)) if1 ();

  fft_out_streamer #(.bits(BITS), .fix_bit(7), .N(N), .BIT_REV(0)) dut0 (
    .clk_100(clk_100), .reset(reset), .bus(if0)
  );
  fft_out_streamer #(.bits(BITS), .fix_bit(7), .N(N), .BIT_REV(1)) dut1 (
    .clk_100(clk_100), .reset(reset), .bus(if1)
  );

  word_t frame_buf [N];
  beat_t q0[$];
  beat_t q1[$];
  int    drops;
  int    tests;
  int    fails;
  view_t obs0, obs1, exp0, exp1;

  function automatic int rev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) r = r * 2 + ((k >> b) % 2);
    return r;
  endfunction

  function automatic word_t tw(input int i);
    return {16'(i), 16'(-i)};
  endfunction

  task automatic push_frame();
    for (int k = 0; k < N; k++) begin
      q0.push_back('{idx: 5'(k), data: frame_buf[k],      last: (k == N - 1)});
      q1.push_back('{idx: 5'(k), data: frame_buf[rev(k)], last: (k == N - 1)});
    end
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < N; i++) frame_buf[i] = word_t'($urandom);
  endtask

  // One clock cycle: drive inputs, capture observed and expected views, advance the model.
  task automatic step(input bit fv, input bit ordy);
    bit has, rdy;
    @(negedge clk_100);
    if0.frame_valid = fv;
    if1.frame_valid = fv;
    if0.out_ready   = ordy;
    if1.out_ready   = ordy;
    for (int i = 0; i < N; i++) begin
      if0.frame_in[i*W +: W] = frame_buf[i];
      if1.frame_in[i*W +: W] = frame_buf[i];
    end
    #1;
    has = (q0.size() > 0);
    rdy = !has || (ordy && q0[0].last);
    exp0 = '0;
    exp1 = '0;
    exp0.fr   = rdy;
    exp1.fr   = rdy;
    exp0.drop = 8'(drops);
    exp1.drop = 8'(drops);
    if (has) begin
      exp0.ov = 1'b1; exp0.busy = 1'b1;
      exp0.idx = q0[0].idx; exp0.data = q0[0].data; exp0.last = q0[0].last;
      exp1.ov = 1'b1; exp1.busy = 1'b1;
      exp1.idx = q1[0].idx; exp1.data = q1[0].data; exp1.last = q1[0].last;
    end
    obs0 = '{if0.out_valid, if0.busy, if0.frame_ready, if0.out_index, if0.out_data, if0.out_last, if0.drop_cnt};
    obs1 = '{if1.out_valid, if1.busy, if1.frame_ready, if1.out_index, if1.out_data, if1.out_last, if1.drop_cnt};
    if (!has) begin
      obs0.idx = '0; obs0.last = 1'b0;
      obs1.idx = '0; obs1.last = 1'b0;
    end
    if (has && ordy) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (fv && rdy) push_frame();
    else if (fv && drops < 255) drops++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if0.frame_valid = 1'b0; if1.frame_valid = 1'b0;
    if0.out_ready   = 1'b0; if1.out_ready   = 1'b0;
    if0.frame_in    = '0;   if1.frame_in    = '0;
    #3;
    tests++;
    if ({if0.out_valid, if0.busy, if0.out_last, if0.out_index, if0.out_data, if0.drop_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_dut0: got v=%b b=%b l=%b i=%0d d=%h drop=%0d want all 0",
               if0.out_valid, if0.busy, if0.out_last, if0.out_index, if0.out_data, if0.drop_cnt);
    end
    tests++;
    if ({if1.out_valid, if1.busy, if1.out_last, if1.out_index, if1.out_data, if1.drop_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_dut1: got v=%b b=%b l=%b i=%0d d=%h drop=%0d want all 0",
               if1.out_valid, if1.busy, if1.out_last, if1.out_index, if1.out_data, if1.drop_cnt);
    end
    tests++;
    if (if0.frame_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_frame_ready: got %b want 1", if0.frame_ready);
    end
    repeat (2) @(negedge clk_100);
    reset = 1'b0;
    q0.delete(); q1.delete(); drops = 0;
  endtask

  task automatic test_single_frame();
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < N; i++) frame_buf[i] = tw(i);
    step(1'b1, 1'b1);
    tests++;
    if (obs0 !== exp0 || obs1 !== exp1) begin
      fails++;
      $display("FAIL single_frame @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
    end
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL single_frame @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
      if (obs0.ov === 1'b1) nvalid++;
    end
    tests++;
    if (nvalid != 32) begin
      fails++;
      $display("FAIL single_frame_beats: got %0d valid cycles want 32", nvalid);
    end
  endtask

  task automatic test_bitrev();
    for (int i = 0; i < N; i++) frame_buf[i] = tw(i);
    step(1'b1, 1'b1);
    for (int c = 0; c < 36; c++) begin
      step(1'b0, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL bitrev @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
      if (exp1.ov && exp1.idx == 5'd1) begin
        tests++;
        if (obs1.data !== tw(16) || obs1.idx !== 5'd1) begin
          fails++;
          $display("FAIL bitrev_beat1: got idx=%0d data=%h want idx=1 data=%h", obs1.idx, obs1.data, tw(16));
        end
      end
      if (exp1.ov && exp1.idx == 5'd3) begin
        tests++;
        if (obs1.data !== tw(24) || obs1.idx !== 5'd3) begin
          fails++;
          $display("FAIL bitrev_beat3: got idx=%0d data=%h want idx=3 data=%h", obs1.idx, obs1.data, tw(24));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int beats;
    bit ordy;
    beats = 0;
    randomize_frame();
    step(1'b1, 1'b1);
    for (int c = 0; c < 120; c++) begin
      ordy = ((c % 3) == 0);
      step(1'b0, ordy);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL backpressure @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
      if (obs0.ov === 1'b1 && ordy) begin
        tests++;
        if (obs0.idx !== 5'(beats)) begin
          fails++;
          $display("FAIL backpressure_order: got index %0d want %0d", obs0.idx, beats);
        end
        beats++;
      end
    end
    tests++;
    if (beats != 32) begin
      fails++;
      $display("FAIL backpressure_beats: got %0d beats want 32", beats);
    end
  endtask

  task automatic test_drop();
    randomize_frame();
    step(1'b1, 1'b1);
    for (int c = 0; c < 11; c++) begin
      if (c == 10) randomize_frame();
      step(c == 10, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL drop @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
    step(1'b0, 1'b1);
    tests++;
    if (obs0.drop !== 8'd1 || obs1.drop !== 8'd1) begin
      fails++;
      $display("FAIL drop_once: got %0d/%0d want 1", obs0.drop, obs1.drop);
    end
    for (int c = 0; c < 300; c++) begin
      step(1'b1, 1'b0);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL drop_stall @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
    step(1'b0, 1'b0);
    tests++;
    if (obs0.drop !== 8'd255 || obs1.drop !== 8'd255) begin
      fails++;
      $display("FAIL drop_saturate: got %0d/%0d want 255", obs0.drop, obs1.drop);
    end
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL drop_drain @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t b0;
    randomize_frame();
    step(1'b1, 1'b1);
    for (int c = 0; c < 31; c++) begin
      step(1'b0, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL b2b_a @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
    randomize_frame();
    b0 = frame_buf[0];
    step(1'b1, 1'b1);
    tests++;
    if (obs0.fr !== 1'b1 || obs0.idx !== 5'd31 || obs0.last !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready: got ready=%b idx=%0d last=%b want ready=1 idx=31 last=1", obs0.fr, obs0.idx, obs0.last);
    end
    step(1'b0, 1'b1);
    tests++;
    if (obs0.ov !== 1'b1 || obs0.idx !== 5'd0 || obs0.data !== b0 || obs0.drop !== 8'd255) begin
      fails++;
      $display("FAIL b2b_first: got v=%b idx=%0d data=%h drop=%0d want v=1 idx=0 data=%h drop=255",
               obs0.ov, obs0.idx, obs0.data, obs0.drop, b0);
    end
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL b2b_b @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
  endtask

  task automatic test_reset_midstream();
    randomize_frame();
    step(1'b1, 1'b1);
    for (int c = 0; c < 18; c++) begin
      step(1'b0, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL midreset_pre @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
    tests++;
    if (obs0.idx !== 5'd17 || obs0.ov !== 1'b1) begin
      fails++;
      $display("FAIL midreset_beat: got idx=%0d v=%b want idx=17 v=1", obs0.idx, obs0.ov);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({if0.out_valid, if0.busy, if0.out_index, if0.out_data, if0.drop_cnt,
         if1.out_valid, if1.busy, if1.out_index, if1.out_data, if1.drop_cnt} !== '0) begin
      fails++;
      $display("FAIL midreset_async: got v=%b b=%b i=%0d d=%h drop=%0d want all 0",
               if0.out_valid, if0.busy, if0.out_index, if0.out_data, if0.drop_cnt);
    end
    q0.delete(); q1.delete(); drops = 0;
    if0.frame_valid = 1'b0; if1.frame_valid = 1'b0;
    @(negedge clk_100);
    @(negedge clk_100);
    reset = 1'b0;
    randomize_frame();
    step(1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL midreset_post @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
  endtask

  task automatic test_random_traffic();
    bit fv, ordy;
    for (int c = 0; c < 700; c++) begin
      randomize_frame();
      fv   = ($urandom_range(0, 5) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      if (c >= 660) begin
        fv   = 1'b0;
        ordy = 1'b1;
      end
      step(fv, ordy);
      tests++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        fails++;
        $display("FAIL random @%0t: dut0 got %h want %h | dut1 got %h want %h", $time, obs0, exp0, obs1, exp1);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    drops = 0;
    test_reset();
    test_single_frame();
    test_bitrev();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_midstream();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want completion before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
